// File: rtl/strip_relu_maxpool_pkg.sv
// Shared types and helpers for the strip ReLU + 2x2 max-pool stage.
// Optional feature macro: STRIP_POOL_RELU_EN (ReLU before the max).
package strip_pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_ADDR_W = 16;

    // Pooled dimensions; an odd trailing column/row is dropped.
    function automatic int pool_out_w(input int in_w);
        return in_w / 2;
    endfunction

    function automatic int pool_out_h(input int in_h);
        return in_h / 2;
    endfunction

endpackage

// File: rtl/strip_relu_maxpool_window.sv
// Per-window running max with optional ReLU clamp on every absorbed sample.
// Optional feature macro: STRIP_POOL_RELU_EN.
module pool_window_max
    import strip_pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] din_i,
    output logic signed [DATA_W-1:0] max_o
);

    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] val;

    // Clamp negatives to zero when ReLU is built in.
    always_comb begin
        val = din_i;
`ifdef STRIP_POOL_RELU_EN
        if (din_i < 0) val = '0;
`endif
    end

    // First sample of a window seeds the max; later samples only raise it.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q <= '0;
        end else if (valid_i) begin
            if (clear_i || (val > max_q)) max_q <= val;
        end
    end

    assign max_o = max_q;

endmodule

// File: rtl/strip_relu_maxpool.sv
// Strip ReLU + 2x2/2 max-pool: reads a conv strip BRAM, writes pooled BRAM.
// Optional feature macro: STRIP_POOL_RELU_EN (ReLU before the max).
module strip_relu_maxpool
    import strip_pool_pkg::*;
#(
    parameter int IN_W     = 222,
    parameter int IN_H     = 28,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int OUT_W = pool_out_w(IN_W);
    localparam int OUT_H = pool_out_h(IN_H);
    localparam int CNT_W = $clog2(READ_LAT + 4);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pr_q, pr_d, pc_q, pc_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [ADDR_W-1:0]   rd_addr_now;
    logic [READ_LAT-1:0] vld_q, first_q;
    logic                issue_now, first_now;
    logic signed [DATA_W-1:0] win_max;

    assign issue_now = (state_q == ST_ISSUE);
    assign first_now = issue_now && (cnt_q == '0);

    // State, counters and held read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            wa_q    <= '0;
            ra_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            wa_q    <= wa_d;
            ra_q    <= ra_d;
        end
    end

    // Valid/first tags travel alongside the BRAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            first_q <= '0;
        end else begin
            vld_q   <= READ_LAT'({vld_q, issue_now});
            first_q <= READ_LAT'({first_q, first_now});
        end
    end

    // Next-state, counter advance and read-address generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        wa_d    = wa_q;
        ra_d    = ra_q;
        // cnt bit1 selects the row, bit0 the column within the 2x2 window
        rd_addr_now = ADDR_W'(((pr_q << 1) + ADDR_W'(cnt_q[1])) * ADDR_W'(IN_W)
                              + (pc_q << 1) + ADDR_W'(cnt_q[0]));
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    pr_d    = '0;
                    pc_d    = '0;
                    wa_d    = '0;
                end
            end
            ST_ISSUE: begin
                ra_d = rd_addr_now;
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                // pooled addresses are sequential in raster order
                wa_d    = wa_q + 1'b1;
                state_d = ST_ISSUE;
                if (pc_q == ADDR_W'(OUT_W - 1)) begin
                    pc_d = '0;
                    if (pr_q == ADDR_W'(OUT_H - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        pr_d = pr_q + 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    pool_window_max #(.DATA_W(DATA_W)) u_max (
        .clk     (clk),
        .reset   (reset),
        .clear_i (first_q[READ_LAT-1]),
        .valid_i (vld_q[READ_LAT-1]),
        .din_i   (rd_data),
        .max_o   (win_max)
    );

    assign rd_addr = issue_now ? rd_addr_now : ra_q;
    assign wr_en   = (state_q == ST_WRITE);
    assign wr_addr = wa_q;
    assign wr_data = win_max;
    assign busy    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
    assign done    = (state_q == ST_FIN);

endmodule
